// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: controller states,
// register-address width and the bubble word loaded into flushed stage registers.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned STAGE_W    = 32;

  // Stage registers load this word when their flush control is high.
  localparam logic [STAGE_W-1:0] BUBBLE_WORD = '0;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detector: the EX instruction is a load whose destination
// (never x0) is a source actually read by the instruction in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  i_ex_is_load,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  output logic                  o_hazard
);

  logic w_rd_live;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rd_live = i_ex_is_load && (i_ex_rd != '0);
  assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_hazard  = w_rd_live && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (INIT/RUN/MEM_WAIT/ERROR).
// Performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned INIT_FLUSH_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT       = 255,
  parameter int unsigned CNT_W             = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_flush,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned INIT_W = $clog2(INIT_FLUSH_CYCLES + 1);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t       r_state, w_state_nxt;
  logic [INIT_W-1:0] r_init_cnt, w_init_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic              w_load_use;
  logic              w_mem_hold;

  load_use_detect u_load_use (
    .i_ex_is_load (ex_is_load),
    .i_ex_rd      (ex_rd),
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_use_rs1 (id_use_rs1),
    .i_id_use_rs2 (id_use_rs2),
    .o_hazard     (w_load_use)
  );

  // In MEM_WAIT only mem_ready matters: the stalled access is still outstanding.
  assign w_mem_hold = ((r_state == RUN) && mem_req && !mem_ready) ||
                      ((r_state == MEM_WAIT) && !mem_ready);

  assign mem_err = (r_state == ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_nxt  = r_init_cnt;
    w_wait_nxt  = r_wait_cnt;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;

    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      unique case (r_state)
        INIT: begin
          ifid_en     = 1'b1;
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
          memwb_en    = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          memwb_flush = 1'b1;
          if (r_init_cnt == INIT_W'(INIT_FLUSH_CYCLES - 1)) begin
            w_state_nxt = RUN;
          end else begin
            w_init_nxt = r_init_cnt + INIT_W'(1);
          end
        end

        RUN, MEM_WAIT: begin
          if (w_mem_hold) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
            if (r_state == RUN) begin
              w_state_nxt = MEM_WAIT;
              w_wait_nxt  = WAIT_W'(1);
            end else if (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
              w_state_nxt = ERROR;
            end else begin
              w_wait_nxt = r_wait_cnt + WAIT_W'(1);
            end
          end else begin
            // Release cycle of MEM_WAIT evaluates hazards exactly like RUN.
            w_state_nxt = RUN;
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            if (ex_branch_taken) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (w_load_use) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
            end
          end
        end

        ERROR: begin
        end

        default: begin
          w_state_nxt = INIT;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_active;
  logic             w_stall_evt;
  logic             w_flush_evt;

  assign w_active    = (r_state == RUN) || (r_state == MEM_WAIT);
  assign w_stall_evt = w_active && !pc_en;
  // A branch flush is the only case with the PC advancing while IF/ID is bubbled.
  assign w_flush_evt = w_active && pc_en && ifid_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table for RUN-state decode plus
// hand-written INIT, memory-wait, timeout and asynchronous-reset sequences.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W = 32;

  // Output bundle order: {mem_err, pc, ifid, idex, exmem, memwb, f_ifid, f_idex, f_memwb}
  localparam logic [8:0] O_RST  = 9'b0_00000_111;
  localparam logic [8:0] O_INIT = 9'b0_01111_111;
  localparam logic [8:0] O_IDLE = 9'b0_11111_000;
  localparam logic [8:0] O_LU   = 9'b0_00111_010;
  localparam logic [8:0] O_BR   = 9'b0_11111_110;
  localparam logic [8:0] O_FRZ  = 9'b0_00001_001;
  localparam logic [8:0] O_ERR  = 9'b1_00000_000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;
  logic             mem_req, mem_ready;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, memwb_flush, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .INIT_FLUSH_CYCLES (4),
    .MEM_TIMEOUT       (8),
    .CNT_W             (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_is_load      (ex_is_load),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_flush     (memwb_flush),
    .mem_err         (mem_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2, ld;
    logic [4:0] rd;
    logic       br, mq, mr;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    string            name;
    logic [8:0]       outs;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } sb_t;

  vec_t             tbl[$];
  sb_t              sb_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  bit               active;
  logic [CNT_W-1:0] m_stall, m_flush;

  function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic ld, logic [4:0] rd, logic br, logic mq, logic mr,
                              logic [8:0] exp);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ld = ld;
    v.rd = rd; v.br = br; v.mq = mq; v.mr = mr; v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] outs_now();
    return {mem_err, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, memwb_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic chk_reset(input string name);
    chk({name, ".outs"}, 32'(outs_now()), 32'(O_RST));
    chk({name, ".stall_cnt"}, stall_cnt, '0);
    chk({name, ".flush_cnt"}, flush_cnt, '0);
  endtask

  // Drive one cycle; the expectation is queued at drive time and checked at the negedge.
  task automatic step(input vec_t v);
    sb_t e;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_is_load = v.ld; ex_rd = v.rd; ex_branch_taken = v.br;
    mem_req = v.mq; mem_ready = v.mr;
    e.name = v.name;
    e.outs = v.exp;
`ifdef PIPE_PERF_CNT_EN
    e.stall = m_stall;
    e.flush = m_flush;
`else
    e.stall = '0;
    e.flush = '0;
`endif
    sb_q.push_back(e);
    if (active && !v.exp[7] && !v.exp[8]) m_stall++;
    if (active && v.exp[7] && v.exp[2]) m_flush++;
    @(negedge clk);
    e = sb_q.pop_front();
    chk({e.name, ".outs"}, 32'(outs_now()), 32'(e.outs));
    chk({e.name, ".stall_cnt"}, stall_cnt, e.stall);
    chk({e.name, ".flush_cnt"}, flush_cnt, e.flush);
    @(posedge clk);
    #1;
  endtask

  task automatic init_seq();
    active  = 1'b0;
    m_stall = '0;
    m_flush = '0;
    for (int i = 0; i < 4; i++) step(mk($sformatf("init%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, O_INIT));
    active = 1'b1;
    step(mk("run_first", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    active = 1'b0; m_stall = '0; m_flush = '0;

    //             name         rs1 rs2 u1 u2 ld rd  br mq mr  expected
    tbl.push_back(mk("idle",      0,  0, 0, 0, 0, 0,  0, 0, 0, O_IDLE));
    tbl.push_back(mk("lu_rs2",    0,  5, 0, 1, 1, 5,  0, 0, 0, O_LU));
    tbl.push_back(mk("lu_rd0",    0,  5, 0, 1, 1, 0,  0, 0, 0, O_IDLE));
    tbl.push_back(mk("x0_match",  0,  0, 1, 1, 1, 0,  0, 0, 0, O_IDLE));
    tbl.push_back(mk("lu_rs1",    7,  0, 1, 0, 1, 7,  0, 0, 0, O_LU));
    tbl.push_back(mk("rs1_nouse", 7,  0, 0, 0, 1, 7,  0, 0, 0, O_IDLE));
    tbl.push_back(mk("rs2_nouse", 3,  9, 1, 0, 1, 9,  0, 0, 0, O_IDLE));
    tbl.push_back(mk("not_load",  7,  0, 1, 0, 0, 7,  0, 0, 0, O_IDLE));
    tbl.push_back(mk("rd_miss",   4,  6, 1, 1, 1, 5,  0, 0, 0, O_IDLE));
    tbl.push_back(mk("lu_r31",    0, 31, 0, 1, 1, 31, 0, 0, 0, O_LU));
    tbl.push_back(mk("branch",    0,  0, 0, 0, 0, 0,  1, 0, 0, O_BR));
    tbl.push_back(mk("br_lu",     0,  5, 0, 1, 1, 5,  1, 0, 0, O_BR));
    tbl.push_back(mk("mem_hit",   0,  0, 0, 0, 0, 0,  0, 1, 1, O_IDLE));

    #3;
    chk_reset("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_seq();

    foreach (tbl[i]) step(tbl[i]);

    for (int i = 0; i < 3; i++) step(mk($sformatf("mw%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
    step(mk("mw_release", 0, 0, 0, 0, 0, 0, 0, 1, 1, O_IDLE));
    step(mk("mw_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));

    step(mk("mwbr_hold",  0, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ));
    step(mk("mwbr_hold2", 0, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ));
    step(mk("mwbr_rel",   0, 0, 0, 0, 0, 0, 1, 1, 1, O_BR));
    step(mk("mwlu_hold",  0, 5, 0, 1, 1, 5, 0, 1, 0, O_FRZ));
    step(mk("mwlu_rel",   0, 5, 0, 1, 1, 5, 0, 1, 1, O_LU));
    step(mk("mwlu_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));

    for (int i = 0; i < 8; i++) step(mk($sformatf("to_wait%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
    step(mk("err0",       0, 0, 0, 0, 0, 0, 0, 1, 0, O_ERR));
    step(mk("err_ready",  0, 0, 0, 0, 0, 0, 0, 1, 1, O_ERR));
    step(mk("err_branch", 0, 5, 0, 1, 1, 5, 1, 0, 0, O_ERR));

    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("err_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    init_seq();

    step(mk("amw0", 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
    step(mk("amw1", 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_mid_wait");
    @(posedge clk);
    #1;
    chk_reset("async_held");
    rst_n = 1'b1;
    init_seq();
    step(mk("post_lu",   0, 5, 0, 1, 1, 5, 0, 0, 0, O_LU));
    step(mk("post_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
